// File: rtl/dual_key_debounce.sv
// Two-channel switch conditioner: each raw key passes through a two-flop synchroniser,
// then a stability counter and FSM that only accept a level held for CNT_MAX cycles.
module dual_key_debounce #(
    parameter int CNT_MAX = 500000,
    parameter int CNT_W   = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic key_a_in,
    input  logic key_b_in,
    output logic a_out,
    output logic b_out,
    output logic a_rise,
    output logic a_fall,
    output logic b_rise,
    output logic b_fall
);

    typedef enum logic {
        ST_STABLE   = 1'b0,
        ST_COUNTING = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [1:0] key_raw;
    logic [1:0] deb_level;
    logic [1:0] deb_rise;
    logic [1:0] deb_fall;

    // Bit 0 is channel A, bit 1 is channel B; the channels share nothing else.
    assign key_raw = {key_b_in, key_a_in};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_chan
            logic             s1_reg;
            logic             s2_reg;
            state_t           state_reg;
            state_t           state_next;
            logic [CNT_W-1:0] cnt_reg;
            logic [CNT_W-1:0] cnt_next;
            logic             out_reg;
            logic             out_next;
            logic             rise_reg;
            logic             rise_next;
            logic             fall_reg;
            logic             fall_next;

            always_ff @(posedge clk) begin
                if (rst) begin
                    s1_reg    <= 1'b0;
                    s2_reg    <= 1'b0;
                    state_reg <= ST_STABLE;
                    cnt_reg   <= '0;
                    out_reg   <= 1'b0;
                    rise_reg  <= 1'b0;
                    fall_reg  <= 1'b0;
                end else begin
                    s1_reg    <= key_raw[gi];
                    s2_reg    <= s1_reg;
                    state_reg <= state_next;
                    cnt_reg   <= cnt_next;
                    out_reg   <= out_next;
                    rise_reg  <= rise_next;
                    fall_reg  <= fall_next;
                end
            end

            always_comb begin
                state_next = state_reg;
                cnt_next   = cnt_reg;
                out_next   = out_reg;
                rise_next  = 1'b0;
                fall_next  = 1'b0;
                case (state_reg)
                    ST_STABLE: begin
                        cnt_next = '0;
                        if (s2_reg != out_reg) begin
                            state_next = ST_COUNTING;
                            cnt_next   = CNT_ONE;
                        end
                    end
                    ST_COUNTING: begin
                        if (s2_reg == out_reg) begin
                            // Bounced back to the accepted level: discard the count.
                            state_next = ST_STABLE;
                            cnt_next   = '0;
                        end else if (cnt_reg == CNT_LAST) begin
                            state_next = ST_STABLE;
                            cnt_next   = '0;
                            out_next   = s2_reg;
                            rise_next  = s2_reg;
                            fall_next  = ~s2_reg;
                        end else begin
                            cnt_next = cnt_reg + CNT_ONE;
                        end
                    end
                    default: begin
                        state_next = ST_STABLE;
                        cnt_next   = '0;
                    end
                endcase
            end

            assign deb_level[gi] = out_reg;
            assign deb_rise[gi]  = rise_reg;
            assign deb_fall[gi]  = fall_reg;
        end
    endgenerate

    assign a_out  = deb_level[0];
    assign b_out  = deb_level[1];
    assign a_rise = deb_rise[0];
    assign b_rise = deb_rise[1];
    assign a_fall = deb_fall[0];
    assign b_fall = deb_fall[1];

endmodule

// File: tb/tb_dual_key_debounce.sv
// Directed bench for dual_key_debounce with CNT_MAX=4: per-cycle vector table,
// two hand-written edge-timing sequences, and a strobe-invariant monitor.
module tb_dual_key_debounce;

    logic clk;
    logic rst;
    logic key_a_in;
    logic key_b_in;
    logic a_out;
    logic b_out;
    logic a_rise;
    logic a_fall;
    logic b_rise;
    logic b_fall;

    int errors = 0;
    int checks = 0;
    logic mon_en = 1'b0;

    dual_key_debounce #(
        .CNT_MAX(4),
        .CNT_W  (3)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .key_a_in(key_a_in),
        .key_b_in(key_b_in),
        .a_out   (a_out),
        .b_out   (b_out),
        .a_rise  (a_rise),
        .a_fall  (a_fall),
        .b_rise  (b_rise),
        .b_fall  (b_fall)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One record per clock edge; exp packs {a_out,a_rise,a_fall,b_out,b_rise,b_fall}
    // as seen just after that edge.
    typedef struct {
        logic       r;
        logic       ka;
        logic       kb;
        logic [5:0] exp;
    } vec_t;

    vec_t vecs[$];

    localparam logic [5:0] E_NONE = 6'b000_000;
    localparam logic [5:0] E_AO   = 6'b100_000;
    localparam logic [5:0] E_AR   = 6'b110_000;
    localparam logic [5:0] E_AF   = 6'b001_000;
    localparam logic [5:0] E_BO   = 6'b000_100;
    localparam logic [5:0] E_BR   = 6'b000_110;
    localparam logic [5:0] E_ABO  = 6'b100_100;

    task automatic hold(input int n, input logic r, input logic ka, input logic kb,
                        input logic [5:0] e);
        vec_t v;
        v.r   = r;
        v.ka  = ka;
        v.kb  = kb;
        v.exp = e;
        repeat (n) vecs.push_back(v);
    endtask

    task automatic build_table();
        // Reset with A held high: all zero, then A accepted at the 6th edge after release.
        hold(3, 1'b1, 1'b1, 1'b0, E_NONE);
        hold(5, 1'b0, 1'b1, 1'b0, E_NONE);
        hold(1, 1'b0, 1'b1, 1'b0, E_AR);
        hold(1, 1'b0, 1'b1, 1'b0, E_AO);
        // A falls, rises, falls again.
        hold(5, 1'b0, 1'b0, 1'b0, E_AO);
        hold(1, 1'b0, 1'b0, 1'b0, E_AF);
        hold(1, 1'b0, 1'b0, 1'b0, E_NONE);
        hold(5, 1'b0, 1'b1, 1'b0, E_NONE);
        hold(1, 1'b0, 1'b1, 1'b0, E_AR);
        hold(1, 1'b0, 1'b1, 1'b0, E_AO);
        hold(5, 1'b0, 1'b0, 1'b0, E_AO);
        hold(1, 1'b0, 1'b0, 1'b0, E_AF);
        hold(1, 1'b0, 1'b0, 1'b0, E_NONE);
        // Glitch on A of CNT_MAX-1 cycles is rejected.
        hold(3, 1'b0, 1'b1, 1'b0, E_NONE);
        hold(6, 1'b0, 1'b0, 1'b0, E_NONE);
        // Both keys rise together, then fall together.
        hold(5, 1'b0, 1'b1, 1'b1, E_NONE);
        hold(1, 1'b0, 1'b1, 1'b1, E_AR | E_BR);
        hold(1, 1'b0, 1'b1, 1'b1, E_ABO);
        hold(5, 1'b0, 1'b0, 1'b0, E_ABO);
        hold(1, 1'b0, 1'b0, 1'b0, E_AF | 6'b000_001);
        hold(1, 1'b0, 1'b0, 1'b0, E_NONE);
        // B bounces 1,0,1,0 in 2-cycle steps, then settles high.
        for (int i = 0; i < 2; i++) begin
            hold(2, 1'b0, 1'b0, 1'b1, E_NONE);
            hold(2, 1'b0, 1'b0, 1'b0, E_NONE);
        end
        hold(5, 1'b0, 1'b0, 1'b1, E_NONE);
        hold(1, 1'b0, 1'b0, 1'b1, E_BR);
        hold(1, 1'b0, 1'b0, 1'b1, E_BO);
        // A goes high, B starts counting toward 0, then reset lands mid-count.
        hold(5, 1'b0, 1'b1, 1'b1, E_BO);
        hold(1, 1'b0, 1'b1, 1'b1, E_AR | E_BO);
        hold(4, 1'b0, 1'b1, 1'b0, E_ABO);
        hold(2, 1'b1, 1'b1, 1'b0, E_NONE);
        hold(5, 1'b0, 1'b1, 1'b0, E_NONE);
        hold(1, 1'b0, 1'b1, 1'b0, E_AR);
        hold(1, 1'b0, 1'b1, 1'b0, E_AO);
    endtask

    // Strobes: never rise+fall together, never high two cycles running.
    logic prev_ar = 1'b0, prev_af = 1'b0, prev_br = 1'b0, prev_bf = 1'b0;
    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if ((a_rise && a_fall) || (b_rise && b_fall) ||
                (a_rise && prev_ar) || (a_fall && prev_af) ||
                (b_rise && prev_br) || (b_fall && prev_bf)) begin
                errors++;
                $display("FAIL strobe_invariant t=%0t got ar=%b af=%b br=%b bf=%b prev=%b%b%b%b want no overlap/repeat",
                         $time, a_rise, a_fall, b_rise, b_fall, prev_ar, prev_af, prev_br, prev_bf);
            end
        end
        prev_ar = a_rise;
        prev_af = a_fall;
        prev_br = b_rise;
        prev_bf = b_fall;
    end

    initial begin
        logic [5:0] got;
        int n;
        bit found;
        int rise_at;
        int fall_at;
        int rise_cnt;
        int fall_cnt;

        rst      = 1'b1;
        key_a_in = 1'b0;
        key_b_in = 1'b0;
        build_table();

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst      = vecs[i].r;
            key_a_in = vecs[i].ka;
            key_b_in = vecs[i].kb;
            @(posedge clk);
            #1;
            mon_en = 1'b1;
            got = {a_out, a_rise, a_fall, b_out, b_rise, b_fall};
            checks++;
            if (got !== vecs[i].exp) begin
                errors++;
                $display("FAIL vec%0d outputs got=%b want=%b (rst=%b ka=%b kb=%b)",
                         i, got, vecs[i].exp, vecs[i].r, vecs[i].ka, vecs[i].kb);
            end else begin
                $display("vec %0d rst=%b ka=%b kb=%b out=%b", i, vecs[i].r,
                         vecs[i].ka, vecs[i].kb, got);
            end
        end

        // A is high here; drop it and time the fall strobe with a bounded wait.
        @(negedge clk);
        key_a_in = 1'b0;
        n = 0;
        found = 1'b0;
        while (n < 20 && !found) begin
            @(posedge clk);
            #1;
            n++;
            if (a_fall) found = 1'b1;
        end
        checks++;
        if (!found || n != 6 || a_out !== 1'b0) begin
            errors++;
            $display("FAIL a_fall_latency got found=%0d edge=%0d a_out=%b want edge=6 a_out=0",
                     found, n, a_out);
        end else begin
            $display("seq a_fall_latency edge=%0d", n);
        end
        @(posedge clk);
        #1;
        checks++;
        if (a_fall !== 1'b0 || a_out !== 1'b0) begin
            errors++;
            $display("FAIL a_fall_single got a_fall=%b a_out=%b want 0 0", a_fall, a_out);
        end else begin
            $display("seq a_fall_single ok");
        end

        // Pulse of exactly CNT_MAX cycles is accepted, then released 4 cycles later.
        rise_at = 0;
        fall_at = 0;
        rise_cnt = 0;
        fall_cnt = 0;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            key_a_in = (i <= 4);
            @(posedge clk);
            #1;
            if (a_rise) begin rise_at = i; rise_cnt++; end
            if (a_fall) begin fall_at = i; fall_cnt++; end
        end
        checks++;
        if (rise_at != 6 || rise_cnt != 1) begin
            errors++;
            $display("FAIL pulse_accept_rise got edge=%0d count=%0d want edge=6 count=1",
                     rise_at, rise_cnt);
        end else begin
            $display("seq pulse_accept_rise edge=%0d", rise_at);
        end
        checks++;
        if (fall_at != 10 || fall_cnt != 1 || a_out !== 1'b0) begin
            errors++;
            $display("FAIL pulse_accept_fall got edge=%0d count=%0d a_out=%b want edge=10 count=1 a_out=0",
                     fall_at, fall_cnt, a_out);
        end else begin
            $display("seq pulse_accept_fall edge=%0d", fall_at);
        end

        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dual_key_debounce.md
Name: dual_key_debounce

Overview:
- Upstream conditioning stage for the two-input logic block on the board.
- Takes two raw, asynchronous, bouncing switch/button signals and produces clean, synchronised, debounced levels that drive that block's `a`/`b` inputs directly.
- Also produces one-cycle rise/fall strobes per channel for downstream counters and LEDs.
- Each channel has an independent two-flop synchroniser, a stability counter and a two-state FSM.

Parameters:
- CNT_MAX, 500000, number of consecutive clk cycles a new level must persist before it is accepted (10 ms at 50 MHz). Legal range is ≥ 2.
- CNT_W, 20, counter width. Requires 2^CNT_W ≥ CNT_MAX.

Ports:
- clk  input  1  system clock, all logic rising-edge.
- rst  input  1  synchronous, active-high reset.
- key_a_in  input  1  raw asynchronous switch/button A.
- key_b_in  input  1  raw asynchronous switch/button B.
- a_out  output  1  debounced level A (feeds logic block input a).
- b_out  output  1  debounced level B (feeds logic block input b).
- a_rise  output  1  one-cycle strobe, a_out went 0→1.
- a_fall  output  1  one-cycle strobe, a_out went 1→0.
- b_rise  output  1  one-cycle strobe, b_out went 0→1.
- b_fall  output  1  one-cycle strobe, b_out went 1→0.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset (rst=1 at an edge) clears the following to 0:
  - sync flops s1, s2 of both channels
  - counters
  - FSM state (STABLE)
  - a_out, b_out and all strobes
- Reset has priority over every other event.
- Synchroniser: s1 <= key_in, s2 <= s1. Only s2 is used downstream; the raw input never reaches the FSM or counter.
- Channels A and B are identical and fully independent. Simultaneous activity on both channels has no interaction.
- FSM per channel:
  - STABLE: s2 == out, cnt held at 0. If s2 != out, go to COUNTING with cnt <= 1.
  - COUNTING, s2 == out (bounce back): cnt <= 0, go to STABLE, out unchanged, no strobe.
  - COUNTING, s2 != out, cnt < CNT_MAX-1: cnt <= cnt+1.
  - COUNTING, s2 != out, cnt == CNT_MAX-1: out <= s2, cnt <= 0, go to STABLE.
    - Assert rise (if s2=1) or fall (if s2=0) for exactly this one cycle, registered together with out.
- Latency: a raw change held stable shows on out, together with its strobe, at the (CNT_MAX+2)th rising edge after the change is first sampled. That is 2 sync cycles plus CNT_MAX stable cycles.
- Glitch rejection: any excursion shorter than CNT_MAX cycles at s2 leaves out unchanged and produces no strobe. The counter restarts from 0 on every return to the current level.
- Strobes:
  - Never high for two consecutive cycles.
  - rise and fall of the same channel are never high together.
  - A strobe is never generated by reset.
- Reset mid-operation:
  - A count in progress is discarded.
  - out drops to 0 immediately, with no fall strobe.
  - If the raw input is held 1 through reset, out rises at edge CNT_MAX+2 after rst deasserts, and rise pulses then.
- Counter never exceeds CNT_MAX-1, so no wrap-around occurs.

Test Plan (CNT_MAX=4, CNT_W=3 for simulation):
- Reset held 3 cycles with key_a_in=1, key_b_in=0 -> all outputs 0 during reset. Release -> a_out=1 and a_rise=1 for one cycle at the 6th edge after release. b_out stays 0 with no strobes.
- key_a_in 0→1 held -> a_out rises at edge 6 after the change with a_rise single-cycle. Then 1→0 held -> a_out falls at edge 6 with a_fall single-cycle, and a_rise stays 0.
- Bounce: key_b_in toggles 1,0,1,0 every 2 cycles, then settles at 1 -> b_out stays 0 through the bounce. b_out rises exactly 6 edges after the final settle, with one b_rise.
- Glitch: key_a_in pulses high for 3 cycles, then returns to 0 -> a_out stays 0 and no strobes are asserted.
- Both keys 0→1 on the same edge -> a_out and b_out rise on the same edge, 6 edges later. a_rise and b_rise are each high for one cycle.
- rst asserted 2 cycles while a_out=1 and a count is in progress on B -> a_out=0 and b counter cleared immediately, with no a_fall. After release, both channels re-debounce from their current input levels.
